// File: rtl/mod_74x191_counter_pkg.sv
// Shared constants for the 74x191 presettable up/down counter.
// Direction encoding matches the D_U pin: low counts up.
package mod_74x191_counter_pkg;

  localparam int   CHIP_WIDTH = 4;
  localparam logic DIR_UP     = 1'b0;
  localparam logic DIR_DOWN   = 1'b1;

endpackage

// File: rtl/mod_74x191_counter_tc_detect.sv
// Terminal-count detect for binary up/down counters.
// Flags all-ones going up and zero going down.
module mod_74x191_counter_tc_detect
  import mod_74x191_counter_pkg::*;
#(
  parameter int WIDTH = CHIP_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             d_u,
  output logic             max_min
);

  logic is_max;
  logic is_min;

  assign is_max  = (q == {WIDTH{1'b1}});
  assign is_min  = (q == {WIDTH{1'b0}});
  assign max_min = (d_u == DIR_DOWN) ? is_min : is_max;

endmodule

// File: rtl/mod_74x191_counter.sv
// 74x191 presettable up/down binary counter with async clear.
// Load beats count; flags are combinational on Q, D_U and CTEN_N.
module mod_74x191_counter
  import mod_74x191_counter_pkg::*;
#(
  parameter int WIDTH = CHIP_WIDTH
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             LOAD_N,
  input  logic             CTEN_N,
  input  logic             D_U,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             MAX_MIN,
  output logic             RCO_N
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_nxt;

  // Ternaries keep an unknown control pin visible as X on Q.
  assign q_step = (D_U == DIR_DOWN) ? (q_r - ONE) : (q_r + ONE);
  assign q_nxt  = !LOAD_N ? D : (!CTEN_N ? q_step : q_r);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) q_r <= '0;
    else     q_r <= q_nxt;
  end

  mod_74x191_counter_tc_detect #(
    .WIDTH(WIDTH)
  ) u_tc (
    .q      (q_r),
    .d_u    (D_U),
    .max_min(MAX_MIN)
  );

  assign Q     = q_r;
  assign RCO_N = ~(MAX_MIN & ~CTEN_N);

endmodule

// File: tb/tb_mod_74x191_counter.sv
// Self-checking bench for mod_74x191_counter.
// Vector table, directed corner cases and a random run vs a model.
module tb_mod_74x191_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         load_n = 1'b1;
  logic         cten_n = 1'b1;
  logic         d_u = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         max_min;
  logic         rco_n;

  int errors = 0;
  int checks = 0;
  int mq = 0;

  mod_74x191_counter #(.WIDTH(W)) dut (
    .CLK    (clk),
    .CLR    (clr),
    .LOAD_N (load_n),
    .CTEN_N (cten_n),
    .D_U    (d_u),
    .D      (d),
    .Q      (q),
    .MAX_MIN(max_min),
    .RCO_N  (rco_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         load_n;
    logic         cten_n;
    logic         d_u;
    logic [W-1:0] d;
    logic [W-1:0] exp_q;
    logic         exp_mm;
    logic         exp_rco;
  } vec_t;

  vec_t vecs[10];

  function automatic int model_next(int cur, logic ld_n, logic ce_n,
                                    logic dir, int din);
    if (!ld_n) return din;
    if (!ce_n) return dir ? (cur + MOD - 1) % MOD : (cur + 1) % MOD;
    return cur;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_model(string name);
    logic mm;
    logic rc;
    mm = d_u ? (mq == 0) : (mq == MOD - 1);
    rc = !(mm && !cten_n);
    chk({name, ".q"}, int'(q), mq);
    chk({name, ".max_min"}, int'(max_min), int'(mm));
    chk({name, ".rco_n"}, int'(rco_n), int'(rc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr) mq = 0;
    else mq = model_next(mq, load_n, cten_n, d_u, int'(d));
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 4'h2, 4'h2, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'hF, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 4'hA, 4'hA, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1};

    // reset state
    #2;
    chk("reset.q", int'(q), 0);
    chk("reset.max_min", int'(max_min), 0);
    chk("reset.rco_n", int'(rco_n), 1);
    tick();
    clr = 1'b0;

    // count a few, then clear mid-cycle
    cten_n = 1'b0;
    d_u = 1'b0;
    repeat (5) tick();
    chk_model("precount");
    #2;
    clr = 1'b1;
    #1;
    mq = 0;
    chk("clr_async.q", int'(q), 0);
    d_u = 1'b1;
    #1;
    chk("clr_du.max_min", int'(max_min), 1);
    chk("clr_du.rco_n", int'(rco_n), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("clr_hold.q", int'(q), 0);
    end
    chk("clr_hold.max_min", int'(max_min), 1);
    clr = 1'b0;

    // vector table
    foreach (vecs[i]) begin
      load_n = vecs[i].load_n;
      cten_n = vecs[i].cten_n;
      d_u    = vecs[i].d_u;
      d      = vecs[i].d;
      tick();
      chk($sformatf("vec%0d.q", i), int'(q), int'(vecs[i].exp_q));
      chk($sformatf("vec%0d.max_min", i), int'(max_min),
          int'(vecs[i].exp_mm));
      chk($sformatf("vec%0d.rco_n", i), int'(rco_n),
          int'(vecs[i].exp_rco));
      chk_model($sformatf("vec%0d.model", i));
    end

    // count up 16 edges with wrap and OR-gate zero detect
    load_n = 1'b0;
    d = '0;
    tick();
    load_n = 1'b1;
    cten_n = 1'b0;
    d_u = 1'b0;
    for (int i = 1; i <= MOD; i++) begin
      logic [1:0] y;
      logic [W-1:0] eq;
      tick();
      eq = W'(i % MOD);
      chk($sformatf("up%0d.q", i), int'(q), int'(eq));
      chk($sformatf("up%0d.max_min", i), int'(max_min),
          int'(eq == 4'hF));
      chk($sformatf("up%0d.rco_n", i), int'(rco_n), int'(eq != 4'hF));
      y = q[1:0] | q[3:2];
      chk($sformatf("or%0d.zero", i), int'(y == 2'b00), int'(eq == 0));
    end

    // direction change without a clock edge
    d_u = 1'b1;
    #1;
    chk("async_du.max_min", int'(max_min), 1);
    chk("async_du.rco_n", int'(rco_n), 0);
    d_u = 1'b0;
    #1;
    chk("async_du_back.max_min", int'(max_min), 0);

    // random run against the model
    for (int i = 0; i < 300; i++) begin
      load_n = ($urandom_range(7) == 0) ? 1'b0 : 1'b1;
      cten_n = ($urandom_range(3) == 0) ? 1'b1 : 1'b0;
      d_u    = ($urandom_range(5) == 0) ? ~d_u : d_u;
      d      = W'($urandom_range(MOD - 1));
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
